alu_sweep_checker: RTL and testbench
====================================

Name: alu_sweep_checker

Overview:
- Sequential self-test engine that sits on the initiator side of the 4-bit arithmetic logic shift unit.
- It drives the ALU's Sel/A/B/Ci/Ir/IL inputs through all 32 {Sel, Ci} codes for one latched operand pair.
- It samples F/Co after a programmable settle time and compares them against an internal golden model of the Mano function table.
- It reports the pass/fail result, the mismatch count and the first failing code; used for power-on ALU self-test and in-system regression.

Parameters:
SETTLE_CYCLES, 1, cycles each vector is held on the ALU inputs before sampling (legal 1..15)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  begin sweep; sampled only in IDLE
A_in  input  4  operand A latched at start
B_in  input  4  operand B latched at start
Ir_in  input  1  serial input for shift right, latched at start
IL_in  input  1  serial input for shift left, latched at start
Sel  output  4  to ALU Sel
A  output  4  to ALU A
B  output  4  to ALU B
Ci  output  1  to ALU Ci
Ir  output  1  to ALU Ir
IL  output  1  to ALU IL
F  input  4  from ALU F
Co  input  1  from ALU Co
busy  output  1  high from LOAD through last SAMPLE
done  output  1  one-cycle pulse at sweep end
pass  output  1  valid when done; 1 = err_count==0
err_count  output  6  number of mismatching vectors (0..32)
first_err_sel  output  4  Sel of first mismatch
first_err_ci  output  1  Ci of first mismatch

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: all outputs 0, state IDLE, vector index 0. rst asserted mid-sweep aborts on the next edge with no done pulse.
- Vector index idx is 5 bits, running 0..31. Sel = idx[4:1], Ci = idx[0]; order is Sel ascending, Ci=0 then Ci=1.
- States and transitions:
  - IDLE: start=1 -> LOAD.
  - LOAD (1 cycle): latch A_in/B_in/Ir_in/IL_in; clear err_count, first_err_*, pass; idx=0 -> DRIVE.
  - DRIVE: hold the vector for SETTLE_CYCLES cycles (down-counter) -> SAMPLE.
  - SAMPLE (1 cycle): compare, update counters; idx==31 -> DONE, else idx+1 -> DRIVE.
  - DONE (1 cycle): done=1 -> IDLE.
- Outputs are registered. A/B/Ir/IL hold the latched operands from LOAD until the next LOAD. Sel/Ci hold the last vector after DONE.
- Latency: done is high in the cycle after edge 1+32*(SETTLE_CYCLES+1), counting the start-sampling edge as edge 0. For SETTLE_CYCLES=1 this is edge 65.
- Golden model; arithmetic uses a 5-bit sum {Co,F}:
  - Sel 0: A+Ci
  - Sel 1: A+B+Ci
  - Sel 2: A+~B+Ci
  - Sel 3: A+4'hF+Ci
  - Sel 4: A&B
  - Sel 5: A|B
  - Sel 6: A^B
  - Sel 7: ~A
  - Sel 8-11: shr, F={Ir,A[3:1]}
  - Sel 12-15: shl, F={A[2:0],IL}
- Comparison: Sel 0-3 compares F and Co. Sel 4-15 compares F only; Co and Ci are don't-care.
- Mismatch handling: err_count increments, saturating at 32. first_err_sel/ci are written only on the first mismatch of the sweep.
- pass is updated at the last SAMPLE and held until the next LOAD. err_count and first_err_* are also held after DONE.
- start in any state other than IDLE is ignored. start held high through DONE relaunches on the IDLE cycle.
- busy=0 in IDLE and DONE.

Optional Feature:
- Macro: ALU_SWEEP_LOG_EN.
- When defined, adds input rd_addr[4:0] and output rd_data[4:0]. Each SAMPLE writes {Co,F} into a 32x5 register log at address idx. rd_data is the registered log[rd_addr] with 1-cycle read latency. The log clears to 0 on rst and is not cleared by LOAD.
- When undefined, the ports and storage are absent and all other behaviour is identical.

Test Plan:
- Correct behavioural ALU, A_in=5, B_in=3, Ir_in=IL_in=0, start pulse -> done at edge 65, pass=1, err_count=0; mid-sweep probes: Sel=1/Ci=0 F=8 Co=0; Sel=2/Ci=1 F=2 Co=1; Sel=3/Ci=0 F=4 Co=1; Sel=6 F=6; Sel=8 F=2; Sel=12 F=10.
- Fault: bench ALU forces F[0]=0 only when Sel=4 (expected 1), same operands -> pass=0, err_count=2, first_err_sel=4, first_err_ci=0.
- Bench drives Co=1 for all Sel>=4, otherwise correct -> pass=1, err_count=0 (Co ignored on logic/shift).
- rst asserted at edge 20 of a sweep -> next cycle all outputs 0, no done pulse; new start -> full sweep completes normally.
- start pulsed again at edges 10 and 40 while busy -> ignored, single done at edge 65; start held high -> second sweep's LOAD follows the IDLE cycle after DONE.
- With ALU_SWEEP_LOG_EN, after the first scenario set rd_addr=5 (Sel 2, Ci 1) -> next cycle rd_data=5'h12; rd_addr=9 (Sel 4, Ci 1) -> rd_data=5'h01.

Source files
------------

// File: rtl/alu_sweep_checker.sv
// Self-test sequencer for the 4-bit Mano ALU: sweeps all 32 {Sel,Ci} codes for one
// latched operand pair and checks F/Co against a golden model. Optional macro ALU_SWEEP_LOG_EN adds a readable result log.
module alu_sweep_checker #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A_in,
    input  logic [3:0] B_in,
    input  logic       Ir_in,
    input  logic       IL_in,
    output logic [3:0] Sel,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       Ci,
    output logic       Ir,
    output logic       IL,
    input  logic [3:0] F,
    input  logic       Co,
`ifdef ALU_SWEEP_LOG_EN
    input  logic [4:0] rd_addr,
    output logic [4:0] rd_data,
`endif
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic [3:0] first_err_sel,
    output logic       first_err_ci
);

    typedef enum logic [2:0] {IDLE, LOAD, DRIVE, SAMPLE, DONE} state_t;

    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic       ir_q, ir_d, il_q, il_d;
    logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [5:0] err_q, err_d;
    logic [3:0] fe_sel_q, fe_sel_d;
    logic       fe_ci_q, fe_ci_d;
    logic [4:0] exp_val;
    logic       mism;

    function automatic logic [4:0] golden(input logic [3:0] sel, input logic ci,
                                          input logic [3:0] a, input logic [3:0] b,
                                          input logic ir, input logic il);
        logic [4:0] r;
        r = 5'd0;
        case (sel)
            4'd0:    r = {1'b0, a} + {4'd0, ci};
            4'd1:    r = {1'b0, a} + {1'b0, b} + {4'd0, ci};
            4'd2:    r = {1'b0, a} + {1'b0, ~b} + {4'd0, ci};
            4'd3:    r = {1'b0, a} + 5'd15 + {4'd0, ci};
            4'd4:    r = {1'b0, a & b};
            4'd5:    r = {1'b0, a | b};
            4'd6:    r = {1'b0, a ^ b};
            4'd7:    r = {1'b0, ~a};
            4'd8, 4'd9, 4'd10, 4'd11: r = {1'b0, ir, a[3:1]};
            default: r = {1'b0, a[2:0], il};
        endcase
        return r;
    endfunction

    // Carry is only meaningful for the arithmetic codes (Sel 0-3).
    always_comb begin
        exp_val = golden(idx_q[4:1], idx_q[0], a_q, b_q, ir_q, il_q);
        if (idx_q[4:3] == 2'b00)
            mism = ({Co, F} != exp_val);
        else
            mism = (F != exp_val[3:0]);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        ir_d     = ir_q;
        il_d     = il_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        fe_sel_d = fe_sel_q;
        fe_ci_d  = fe_ci_q;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                a_d      = A_in;
                b_d      = B_in;
                ir_d     = Ir_in;
                il_d     = IL_in;
                err_d    = 6'd0;
                fe_sel_d = 4'd0;
                fe_ci_d  = 1'b0;
                pass_d   = 1'b0;
                idx_d    = 5'd0;
                cnt_d    = 4'(SETTLE_CYCLES);
                state_d  = DRIVE;
            end
            DRIVE: begin
                if (cnt_q <= 4'd1) state_d = SAMPLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            SAMPLE: begin
                if (mism) begin
                    if (err_q != 6'd32) err_d = err_q + 6'd1;
                    if (err_q == 6'd0) begin
                        fe_sel_d = idx_q[4:1];
                        fe_ci_d  = idx_q[0];
                    end
                end
                if (idx_q == 5'd31) begin
                    pass_d  = (err_d == 6'd0);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    cnt_d   = 4'(SETTLE_CYCLES);
                    state_d = DRIVE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOAD) || (state_d == DRIVE) || (state_d == SAMPLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 5'd0;
            cnt_q    <= 4'd0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            ir_q     <= 1'b0;
            il_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 6'd0;
            fe_sel_q <= 4'd0;
            fe_ci_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ir_q     <= ir_d;
            il_q     <= il_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fe_sel_q <= fe_sel_d;
            fe_ci_q  <= fe_ci_d;
        end
    end

`ifdef ALU_SWEEP_LOG_EN
    logic [4:0] log_q [32];
    logic [4:0] rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) log_q[i] <= 5'd0;
            rd_q <= 5'd0;
        end else begin
            if (state_q == SAMPLE) log_q[idx_q] <= {Co, F};
            rd_q <= log_q[rd_addr];
        end
    end

    assign rd_data = rd_q;
`endif

    assign Sel           = idx_q[4:1];
    assign Ci            = idx_q[0];
    assign A             = a_q;
    assign B             = b_q;
    assign Ir            = ir_q;
    assign IL            = il_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_sel = fe_sel_q;
    assign first_err_ci  = fe_ci_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Directed bench for alu_sweep_checker with a behavioural ALU that can inject faults.
module tb_alu_sweep_checker;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] A_in, B_in;
    logic       Ir_in, IL_in;
    logic [3:0] Sel, A, B, F;
    logic       Ci, Ir, IL, Co;
    logic       busy, done, pass;
    logic [5:0] err_count;
    logic [3:0] first_err_sel;
    logic       first_err_ci;
`ifdef ALU_SWEEP_LOG_EN
    logic [4:0] rd_addr = 5'd0;
    logic [4:0] rd_data;
`endif

    int checks = 0;
    int errors = 0;
    int fault  = 0;   // 0 good ALU, 1 F[0] stuck 0 at Sel 4, 2 Co=1 for Sel>=4
    int first_done, ndone;
    logic bz [0:80];

    always #5 clk = ~clk;

    alu_sweep_checker #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .A_in(A_in), .B_in(B_in), .Ir_in(Ir_in), .IL_in(IL_in),
        .Sel(Sel), .A(A), .B(B), .Ci(Ci), .Ir(Ir), .IL(IL),
        .F(F), .Co(Co),
`ifdef ALU_SWEEP_LOG_EN
        .rd_addr(rd_addr), .rd_data(rd_data),
`endif
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_sel(first_err_sel), .first_err_ci(first_err_ci)
    );

    // Behavioural ALU under test
    logic [4:0] s5;
    always_comb begin
        s5 = 5'd0;
        case (Sel)
            4'd0: s5 = {1'b0, A} + {4'd0, Ci};
            4'd1: s5 = {1'b0, A} + {1'b0, B} + {4'd0, Ci};
            4'd2: s5 = {1'b0, A} + {1'b0, ~B} + {4'd0, Ci};
            4'd3: s5 = {1'b0, A} + 5'd15 + {4'd0, Ci};
            4'd4: s5 = {1'b0, A & B};
            4'd5: s5 = {1'b0, A | B};
            4'd6: s5 = {1'b0, A ^ B};
            4'd7: s5 = {1'b0, ~A};
            4'd8, 4'd9, 4'd10, 4'd11: s5 = {1'b0, Ir, A[3:1]};
            default: s5 = {1'b0, A[2:0], IL};
        endcase
        if (fault == 1 && Sel == 4'd4) s5[0] = 1'b0;
        if (fault == 2 && Sel >= 4'd4) s5[4] = 1'b1;
        F  = s5[3:0];
        Co = s5[4];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Start at edge 0, then observe 70 edges. Extra start pulses at pa/pb,
    // optional start held high, optional reset at edge rst_at.
    task automatic sweep(input int pa, input int pb, input bit hold, input int rst_at,
                         input bit probe);
        first_done = -1;
        ndone      = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int e = 1; e <= 70; e++) begin
            start = hold || (e == pa) || (e == pb);
            rst   = (e == rst_at);
            @(posedge clk);
            @(negedge clk);
            bz[e] = busy;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = e;
            end
            if (e == rst_at) begin
                chk("rst_sel_ci", {Sel, Ci}, 0);
                chk("rst_ab", {A, B, Ir, IL}, 0);
                chk("rst_flags", {busy, done, pass}, 0);
                chk("rst_err", {err_count, first_err_sel, first_err_ci}, 0);
            end
            if (probe && busy) begin
                if (Sel == 4'd1 && !Ci) chk("probe_s1c0", {Co, F}, 8);
                if (Sel == 4'd2 &&  Ci) chk("probe_s2c1", {Co, F}, 5'h12);
                if (Sel == 4'd3 && !Ci) chk("probe_s3c0", {Co, F}, 5'h14);
                if (Sel == 4'd6) chk("probe_s6", F, 6);
                if (Sel == 4'd8) chk("probe_s8", F, 2);
                if (Sel == 4'd12) chk("probe_s12", F, 10);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        A_in = 4'd5; B_in = 4'd3; Ir_in = 1'b0; IL_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {Sel, A, B, Ci, Ir, IL, busy, done, pass}, 0);
        chk("reset_err", {err_count, first_err_sel, first_err_ci}, 0);
        rst = 1'b0;

        // Good ALU
        sweep(0, 0, 1'b0, 0, 1'b1);
        chk("good_done_edge", first_done, 65);
        chk("good_ndone", ndone, 1);
        chk("good_pass", pass, 1);
        chk("good_err", err_count, 0);
        chk("good_busy_last", bz[64], 1);
        chk("good_busy_done", bz[65], 0);
        chk("good_hold_ab", {A, B}, 8'h53);
        chk("good_hold_sel", {Sel, Ci}, 31);
`ifdef ALU_SWEEP_LOG_EN
        rd_addr = 5'd5;
        @(posedge clk); @(negedge clk);
        chk("log_5", rd_data, 5'h12);
        rd_addr = 5'd9;
        @(posedge clk); @(negedge clk);
        chk("log_9", rd_data, 5'h01);
`endif

        // F[0] stuck at Sel 4
        fault = 1;
        sweep(0, 0, 1'b0, 0, 1'b0);
        chk("f1_done_edge", first_done, 65);
        chk("f1_pass", pass, 0);
        chk("f1_err", err_count, 2);
        chk("f1_first_sel", first_err_sel, 4);
        chk("f1_first_ci", first_err_ci, 0);
        repeat (3) @(negedge clk);
        chk("f1_err_held", {pass, err_count}, 2);

        // Reset mid-sweep
        sweep(0, 0, 1'b0, 20, 1'b0);
        chk("rst_ndone", ndone, 0);

        // Carry noise on logic/shift codes must be ignored
        fault = 2;
        sweep(0, 0, 1'b0, 0, 1'b0);
        chk("f2_done_edge", first_done, 65);
        chk("f2_pass", pass, 1);
        chk("f2_err", err_count, 0);

        // Start pulses while busy are ignored
        fault = 0;
        sweep(10, 40, 1'b0, 0, 1'b0);
        chk("pulse_done_edge", first_done, 65);
        chk("pulse_ndone", ndone, 1);
        chk("pulse_idle", bz[70], 0);

        // Start held: relaunch after the IDLE cycle following DONE
        sweep(0, 0, 1'b1, 0, 1'b0);
        chk("hold_done_edge", first_done, 65);
        chk("hold_busy66", bz[66], 0);
        chk("hold_busy67", bz[67], 1);
        chk("hold_ndone", ndone, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
